// File: rtl/aluout_queue.sv
// ---------------------------------------------------------------------------
// aluout_queue
//   DEPTH-entry FIFO that buffers ALU results together with their zero flag.
//   It sits between the ALU output and the register-file write /
//   memory-address mux. The ALU keeps producing results while the
//   consumers stall.
//
// Parameters
//   WIDTH : ALU result width (default 32)
//   DEPTH : number of entries, a power of two and at least 2 (default 2)
//   CW    : width of count, $clog2(DEPTH)+1 (localparam)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   flush     in   synchronous discard of every entry (branch / exception)
//   in_valid  in   ALU result valid
//   in_ready  out  queue can accept a result (count < DEPTH)
//   in_data   in   ALU result
//   in_zero   in   ALU zero flag
//   out_valid out  head entry valid
//   out_ready in   consumer takes the head entry
//   out_data  out  head result (0 when nothing is valid)
//   out_zero  out  head zero flag (0 when nothing is valid)
//   count     out  number of stored entries, 0..DEPTH
//
// Optional feature
//   ALUOUT_QUEUE_BYPASS_EN : when the queue is empty, an incoming result is
//   presented at the output in the same cycle. If the consumer takes it in
//   that cycle, it is never written into storage.
// ---------------------------------------------------------------------------
module aluout_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = WIDTH + 1;  // stored entry is {zero, data}

  // Storage is left unreset; count_q qualifies every read.
  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic stored_valid_s;  // at least one entry in storage
  logic byp_s;           // bypass path presents in_data at the output
  logic push_s;          // accepted input handshake (not flushed)
  logic pop_s;           // accepted output handshake (not flushed)
  logic wr_en_s;         // accepted entry actually written to storage
  logic rd_en_s;         // head of storage consumed

  // Queue status derived from registered state only.
  assign stored_valid_s = (count_q != {CW{1'b0}});
  assign in_ready       = (count_q < CW'(DEPTH));
  assign count          = count_q;

`ifdef ALUOUT_QUEUE_BYPASS_EN
  assign byp_s = !stored_valid_s && in_valid && !flush;
`else
  assign byp_s = 1'b0;
`endif

  // Flush overrides both handshakes, so neither side counts as taken.
  assign push_s = in_valid && in_ready && !flush;
  assign pop_s  = out_valid && out_ready && !flush;

  // A bypassed entry that the consumer takes immediately never enters storage.
  assign wr_en_s = push_s && !(byp_s && out_ready);
  assign rd_en_s = pop_s && stored_valid_s;

  // Output mux: storage head first, then the bypass path, otherwise zeros.
  always_comb begin
    out_valid = 1'b0;
    out_data  = {WIDTH{1'b0}};
    out_zero  = 1'b0;
    if (stored_valid_s) begin
      out_valid = 1'b1;
      out_data  = mem_q[rd_ptr_q][WIDTH-1:0];
      out_zero  = mem_q[rd_ptr_q][WIDTH];
    end else if (byp_s) begin
      out_valid = 1'b1;
      out_data  = in_data;
      out_zero  = in_zero;
    end else begin
      out_valid = 1'b0;
      out_data  = {WIDTH{1'b0}};
      out_zero  = 1'b0;
    end
  end

  // Next-state logic for the pointers and the occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      // DEPTH is a power of two, so the natural wrap of PW bits is modulo DEPTH.
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= {in_zero, in_data};
    end
  end

endmodule

// File: doc/aluout_queue.md
Name: aluout_queue

Overview:
- Parametrised successor to the single-register ALU result latch in the multi-cycle CPU datapath.
- Buffers ALU results, each with its zero flag, in a DEPTH-entry FIFO.
- Uses a valid/ready handshake at both ends, so the ALU can keep producing while writeback or memory-address consumers stall.
- Sits between the ALU output and the register-file write / memory-address mux.

Parameters:
- WIDTH, 32, data width of the ALU result.
- DEPTH, 2, number of entries; must be a power of two and at least 2.
- CW (localparam), $clog2(DEPTH)+1, width of the count output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all entries; used on branch or exception.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  queue can accept a result this cycle.
- in_data  input  WIDTH  ALU result.
- in_zero  input  1  ALU zero flag, stored alongside the result.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_data  output  WIDTH  head result.
- out_zero  output  1  head zero flag.
- count  output  CW  number of stored entries, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_data=0, out_zero=0. Storage contents are don't-care.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready. Both are sampled on the rising edge.
- in_ready = (count < DEPTH). It is registered-state only and never depends on out_ready.
  - A full queue refuses a push even when a pop happens in the same cycle.
- out_valid = (count != 0).
- out_data and out_zero = storage[rd_ptr] when out_valid, otherwise 0.
- Latency: a pushed entry is visible at the output on the cycle after acceptance, so the minimum is 1 cycle.
- Pointers increment modulo DEPTH. Wrap-around from DEPTH-1 to 0 must not disturb data.
- Count rules:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Order is strictly FIFO.
- No overflow or underflow: pushes while full and pops while empty are impossible by construction (in_ready / out_valid gate them). in_data is ignored when no push occurs.
- Flush:
  - Synchronous and highest priority.
  - Next cycle: count=0, rd_ptr=wr_ptr=0, out_valid=0.
  - A push or pop in the same cycle as flush is discarded, and the pop does not count as taken.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge.
- Deassertion of rst_n is assumed synchronised externally.

Optional Feature:
- Macro: ALUOUT_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and in_valid=1 and flush=0, out_valid=1 combinationally, with out_data=in_data and out_zero=in_zero in the same cycle.
  - If out_ready=1 in that cycle, the entry is consumed and not written into storage; count stays 0.
  - Otherwise it is stored normally.
  - in_ready is unchanged.
- Not defined: the output is purely from storage, with a minimum latency of 1 cycle as above.

Test Plan:
- Reset: hold rst_n=0 mid-stream with count=2 -> out_valid=0, count=0, in_ready=1 immediately, before any clock edge.
- Basic FIFO, DEPTH=2, out_ready=0: push 0x0000_0005 (zero=0), then 0x0000_0000 (zero=1) -> count=2, in_ready=0. Then out_ready=1 -> pops 0x5 zero=0, then 0x0 zero=1, in order.
- Full plus simultaneous: queue full, in_valid=1, out_ready=1 -> one pop, push refused, count=1. Next cycle push+pop together -> count stays 1.
- Wrap-around: stream 10 sequential values 1..10 with out_ready toggling 1,0,1,0 -> output sequence is exactly 1..10 and count never exceeds 2.
- Flush: count=2, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0. The next push 0xDEAD_BEEF appears as the head.
- Bypass (ALUOUT_QUEUE_BYPASS_EN): empty queue, in_valid=1, in_data=0x1234, out_ready=1 -> out_valid=1 and out_data=0x1234 in the same cycle, count stays 0. Without the macro, the value appears one cycle later.
